// File: rtl/param_buf.sv
// Run-time loadable convolution weight/bias buffer: streams one kernel's
// KW columns (KH taps each) with valid/last framing and the kernel's bias.
module param_buf #(
  parameter int DW   = 16,
  parameter int KH   = 5,
  parameter int KW   = 5,
  parameter int NKER = 32,
  parameter int AW   = $clog2(NKER*KW),
  parameter int KIW  = $clog2(NKER),
  parameter int SW   = $clog2(KH+1)
) (
  input  logic                   sclk,
  input  logic                   s_rst_n,
  input  logic                   ld_en,
  input  logic [SW-1:0]          ld_sel,
  input  logic [AW-1:0]          ld_addr,
  input  logic [DW-1:0]          ld_data,
  output logic                   ld_rdy,
  input  logic                   start,
  input  logic [KIW-1:0]         ker_idx,
  output logic                   busy,
  output logic                   err,
  output logic                   w_vld,
  output logic                   w_last,
  output logic [$clog2(KW)-1:0]  w_col,
  output logic [KH*DW-1:0]       w_data,
  output logic [DW-1:0]          bias
);

  localparam int CW  = $clog2(KW);
  localparam int BIW = $clog2(NKER);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [AW-1:0]   base_q, base_d;
  logic [BIW-1:0]  kidx_q, kidx_d;
  logic            issue;
  logic            start_bad;

  logic [AW-1:0]   raddr_q;
  logic            avld_q, alast_q;
  logic [CW-1:0]   acol_q;
  logic            vld_q, last_q, err_q;
  logic [CW-1:0]   wcol_q;
  logic [DW-1:0]   bias_q;

  logic            sel_bad, addr_bad, ld_bad, wr_w, wr_b;
  logic [DW-1:0]   bmem [NKER];

  assign busy   = (state_q != S_IDLE);
  assign ld_rdy = ~busy;

  // Out-of-range addresses are rejected so they can never alias a valid word.
  assign sel_bad  = (ld_sel > SW'(KH));
  assign addr_bad = (ld_sel == SW'(KH)) ? ({1'b0, ld_addr} >= (AW+1)'(NKER))
                                        : ({1'b0, ld_addr} >= (AW+1)'(NKER*KW));
  assign ld_bad   = ld_en & (busy | sel_bad | addr_bad);
  assign wr_w     = ld_en & ~ld_bad & (ld_sel < SW'(KH));
  assign wr_b     = ld_en & ~ld_bad & (ld_sel == SW'(KH));

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    base_d    = base_q;
    kidx_d    = kidx_q;
    issue     = 1'b0;
    start_bad = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if ({1'b0, ker_idx} >= (KIW+1)'(NKER)) begin
            start_bad = 1'b1;
          end else begin
            state_d = S_RUN;
            base_d  = AW'(ker_idx * KW);
            kidx_d  = ker_idx[BIW-1:0];
            col_d   = '0;
          end
        end
      end
      S_RUN: begin
        issue = 1'b1;
        col_d = col_q + CW'(1);
        if (col_q == CW'(KW-1)) begin
          state_d = S_DRAIN;
          col_d   = '0;
        end
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      base_q  <= '0;
      kidx_q  <= '0;
      raddr_q <= '0;
      avld_q  <= 1'b0;
      acol_q  <= '0;
      alast_q <= 1'b0;
      vld_q   <= 1'b0;
      wcol_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      bias_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      base_q  <= base_d;
      kidx_q  <= kidx_d;
      raddr_q <= base_q + AW'(col_q);
      avld_q  <= issue;
      acol_q  <= col_q;
      alast_q <= issue && (col_q == CW'(KW-1));
      vld_q   <= avld_q;
      last_q  <= alast_q;
      if (avld_q) wcol_q <= acol_q;
      err_q   <= start_bad | ld_bad;
      // Bias is read a cycle after acceptance so a same-cycle bias load is seen.
      if (state_q == S_RUN && col_q == '0) bias_q <= bmem[kidx_q];
    end
  end

  always_ff @(posedge sclk) begin
    if (wr_b) bmem[ld_addr[BIW-1:0]] <= ld_data;
  end

  genvar r;
  for (r = 0; r < KH; r++) begin : g_row
    logic [DW-1:0] mem [NKER*KW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge sclk) begin
      if (wr_w && ld_sel == SW'(r)) mem[ld_addr] <= ld_data;
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n)    rdata_q <= '0;
      else if (avld_q) rdata_q <= mem[raddr_q];
    end

    assign w_data[r*DW +: DW] = rdata_q;
  end

  assign err    = err_q;
  assign w_vld  = vld_q;
  assign w_last = last_q;
  assign w_col  = wcol_q;
  assign bias   = bias_q;

endmodule
